// File: rtl/pmu_quota_window_ctrl_if.sv
// Bundle of the configuration-side and quota-unit-side signals of the PMU
// quota window scheduler. The controller uses the slave modport; the
// configuration block / bench drives through the master modport.
//
// Protocol note: there is no valid/ready stream on this bus. The only
// handshake is irq_o / irq_ack_i: irq_o is a sticky level, irq_ack_i is a
// single-cycle strobe that clears it, and a window-end overrun arriving in
// the same cycle as the strobe keeps irq_o set.
interface pmu_quota_window_ctrl_if #(
  parameter int N_CORES   = 4,
  parameter int REG_WIDTH = 32,
  parameter int CNT_W     = 8
);
  logic                     enable_i;
  logic [REG_WIDTH-1:0]     window_len_i;
  logic [N_CORES-1:0]       intr_quota_i;
  logic                     irq_ack_i;
  logic                     clr_cnt_i;
  logic                     softrst_o;
  logic [N_CORES-1:0]       throttle_o;
  logic [N_CORES-1:0]       overrun_o;
  logic [N_CORES*CNT_W-1:0] overrun_cnt_o;
  logic                     irq_o;
  logic [2:0]               state_o;

  modport master (
    output enable_i, window_len_i, intr_quota_i, irq_ack_i, clr_cnt_i,
    input  softrst_o, throttle_o, overrun_o, overrun_cnt_o, irq_o, state_o
  );

  modport slave (
    input  enable_i, window_len_i, intr_quota_i, irq_ack_i, clr_cnt_i,
    output softrst_o, throttle_o, overrun_o, overrun_cnt_o, irq_o, state_o
  );
endinterface

// File: rtl/pmu_quota_window_ctrl.sv
// Periodic budget scheduler for the per-core PMU quota units.
// Window sequence: REPL (soft reset pulse, latch length) -> RUN (L cycles)
// -> DRAIN (N_COUNTERS+1 cycles for the quota adders to finish a sweep)
// -> SAMPLE (snapshot overruns) -> REPL again. Dropping enable or writing a
// zero length during RUN/DRAIN flushes through REPL to IDLE without SAMPLE.
module pmu_quota_window_ctrl #(
  parameter int N_CORES    = 4,
  parameter int N_COUNTERS = 9,
  parameter int REG_WIDTH  = 32,
  parameter int CNT_W      = 8
) (
  input logic                   clk_i,
  input logic                   rst_i,
  pmu_quota_window_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REPL   = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_SAMPLE = 3'd4
  } state_t;

  localparam logic [REG_WIDTH-1:0] TIMER_ONE  = REG_WIDTH'(1);
  localparam logic [REG_WIDTH-1:0] DRAIN_LAST = REG_WIDTH'(N_COUNTERS);
  localparam logic [CNT_W-1:0]     CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]     CNT_MAX    = '1;

  state_t               state_q, state_d;
  logic [REG_WIDTH-1:0] timer_q, timer_d;
  logic [REG_WIDTH-1:0] len_q, len_d;
  logic [N_CORES-1:0]   throttle_q, throttle_d;
  logic [N_CORES-1:0]   overrun_q, overrun_d;
  logic                 irq_q, irq_d;
  logic [CNT_W-1:0]     cnt_q [N_CORES];
  logic [CNT_W-1:0]     cnt_d [N_CORES];
  logic [N_CORES*CNT_W-1:0] cnt_flat;

  // A window may run only while enabled with a non-zero length programmed.
  logic go_ok;
  assign go_ok = bus.enable_i && (bus.window_len_i != '0);

  // Next state, window timer and length latch.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    len_d   = len_q;
    case (state_q)
      ST_IDLE: begin
        if (go_ok) state_d = ST_REPL;
      end
      ST_REPL: begin
        len_d   = bus.window_len_i;
        timer_d = '0;
        state_d = go_ok ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        if (!go_ok) begin
          state_d = ST_REPL;
        end else if (timer_q == len_q - TIMER_ONE) begin
          state_d = ST_DRAIN;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end
      ST_DRAIN: begin
        if (!go_ok) begin
          state_d = ST_REPL;
        end else if (timer_q == DRAIN_LAST) begin
          state_d = ST_SAMPLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end
      ST_SAMPLE: begin
        state_d = ST_REPL;
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Throttle flags: accumulate while the window is live, cleared on entry to
  // REPL so they read zero during the replenish pulse.
  always_comb begin
    throttle_d = throttle_q;
    if (state_q == ST_RUN || state_q == ST_DRAIN) begin
      throttle_d = throttle_q | bus.intr_quota_i;
    end
    if (state_d == ST_REPL) begin
      throttle_d = '0;
    end
  end

  // Overrun snapshot and sticky interrupt; a fresh overrun beats the ack.
  always_comb begin
    overrun_d = overrun_q;
    irq_d     = irq_q;
    if (bus.irq_ack_i) begin
      irq_d = 1'b0;
    end
    if (state_q == ST_SAMPLE) begin
      overrun_d = bus.intr_quota_i;
      if (|bus.intr_quota_i) irq_d = 1'b1;
    end
  end

  // Saturating per-core overrun counters; a clear beats an increment.
  always_comb begin
    for (int c = 0; c < N_CORES; c++) begin
      cnt_d[c] = cnt_q[c];
      if (bus.clr_cnt_i) begin
        cnt_d[c] = '0;
      end else if (state_q == ST_SAMPLE && bus.intr_quota_i[c] && cnt_q[c] != CNT_MAX) begin
        cnt_d[c] = cnt_q[c] + CNT_ONE;
      end
    end
  end

  // Pack the counters onto the flat output bus, core c at [c*CNT_W +: CNT_W].
  always_comb begin
    cnt_flat = '0;
    for (int c = 0; c < N_CORES; c++) begin
      cnt_flat[c*CNT_W +: CNT_W] = cnt_q[c];
    end
  end

  // State registers; reset returns to IDLE with every output low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      len_q      <= '0;
      throttle_q <= '0;
      overrun_q  <= '0;
      irq_q      <= 1'b0;
      for (int c = 0; c < N_CORES; c++) cnt_q[c] <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      len_q      <= len_d;
      throttle_q <= throttle_d;
      overrun_q  <= overrun_d;
      irq_q      <= irq_d;
      for (int c = 0; c < N_CORES; c++) cnt_q[c] <= cnt_d[c];
    end
  end

  assign bus.softrst_o     = (state_q == ST_REPL);
  assign bus.throttle_o    = throttle_q;
  assign bus.overrun_o     = overrun_q;
  assign bus.overrun_cnt_o = cnt_flat;
  assign bus.irq_o         = irq_q;
  assign bus.state_o       = state_q;

endmodule

// File: tb/tb_pmu_quota_window_ctrl.sv
// Directed bench for pmu_quota_window_ctrl (N_CORES=4, N_COUNTERS=9, CNT_W=8).
// Time index t counts cycles from the REPL cycle of the first window
// (t=0); window of length L: RUN t=1..L, DRAIN t=L+1..L+10, SAMPLE t=L+11,
// next REPL t=L+12.
module tb_pmu_quota_window_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pmu_quota_window_ctrl_if #(.N_CORES(4), .REG_WIDTH(32), .CNT_W(8)) bus ();

  pmu_quota_window_ctrl #(
    .N_CORES(4), .N_COUNTERS(9), .REG_WIDTH(32), .CNT_W(8)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n cycles; observation point is 1 time unit after the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected FSM state at time index t of a window of length l.
  function automatic logic [2:0] exp_state(input int t, input int l);
    if (t == 0 || t == l + 12) return 3'd1;
    if (t <= l)                return 3'd2;
    if (t <= l + 10)           return 3'd3;
    return 3'd4;
  endfunction

  // Driver: return to a clean reset with all inputs idle.
  task automatic reset_dut();
    rst              = 1'b1;
    bus.enable_i     = 1'b0;
    bus.window_len_i = '0;
    bus.intr_quota_i = '0;
    bus.irq_ack_i    = 1'b0;
    bus.clr_cnt_i    = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    checks++; if (bus.state_o !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", bus.state_o); end
    checks++; if (bus.softrst_o !== 1'b0) begin errors++; $display("FAIL reset_softrst: got %0b expected 0", bus.softrst_o); end
    checks++; if (bus.throttle_o !== 4'h0) begin errors++; $display("FAIL reset_throttle: got %0h expected 0", bus.throttle_o); end
    checks++; if (bus.overrun_o !== 4'h0) begin errors++; $display("FAIL reset_overrun: got %0h expected 0", bus.overrun_o); end
    checks++; if (bus.overrun_cnt_o !== 32'h0) begin errors++; $display("FAIL reset_cnt: got %0h expected 0", bus.overrun_cnt_o); end
    checks++; if (bus.irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq: got %0b expected 0", bus.irq_o); end
    // Enabled with zero length stays idle.
    bus.enable_i = 1'b1;
    tick(3);
    checks++; if (bus.state_o !== 3'd0) begin errors++; $display("FAIL zero_len_idle: got %0d expected 0", bus.state_o); end
  endtask

  task automatic test_period();
    reset_dut();
    bus.window_len_i = 32'd20;
    bus.enable_i     = 1'b1;
    tick(1);
    checks++; if (bus.state_o !== 3'd1 || bus.softrst_o !== 1'b1) begin
      errors++; $display("FAIL period_first_repl: got state %0d softrst %0b expected 1 1", bus.state_o, bus.softrst_o);
    end
    for (int t = 1; t <= 64; t++) begin
      tick(1);
      checks++; if (bus.state_o !== exp_state(t % 32, 20)) begin
        errors++; $display("FAIL period_state t=%0d: got %0d expected %0d", t, bus.state_o, exp_state(t % 32, 20));
      end
      checks++; if (bus.softrst_o !== ((t % 32) == 0)) begin
        errors++; $display("FAIL period_softrst t=%0d: got %0b expected %0b", t, bus.softrst_o, ((t % 32) == 0));
      end
      checks++; if (bus.irq_o !== 1'b0) begin errors++; $display("FAIL period_irq t=%0d: got %0b expected 0", t, bus.irq_o); end
    end
    checks++; if (bus.overrun_cnt_o !== 32'h0) begin errors++; $display("FAIL period_cnt: got %0h expected 0", bus.overrun_cnt_o); end
  endtask

  task automatic test_overrun();
    reset_dut();
    bus.window_len_i = 32'd20;
    bus.enable_i     = 1'b1;
    tick(1);          // t=0
    tick(5);          // t=5, RUN cycle 5
    checks++; if (bus.throttle_o !== 4'h0) begin errors++; $display("FAIL ovr_throttle_pre: got %0h expected 0", bus.throttle_o); end
    bus.intr_quota_i = 4'b0100;
    tick(1);          // t=6
    checks++; if (bus.throttle_o !== 4'b0100) begin errors++; $display("FAIL ovr_throttle_set: got %0h expected 4", bus.throttle_o); end
    tick(25);         // t=31 SAMPLE
    checks++; if (bus.state_o !== 3'd4 || bus.throttle_o !== 4'b0100) begin
      errors++; $display("FAIL ovr_sample: got state %0d throttle %0h expected 4 4", bus.state_o, bus.throttle_o);
    end
    tick(1);          // t=32 REPL
    checks++; if (bus.overrun_o !== 4'b0100) begin errors++; $display("FAIL ovr_snapshot: got %0h expected 4", bus.overrun_o); end
    checks++; if (bus.overrun_cnt_o !== 32'h0001_0000) begin errors++; $display("FAIL ovr_cnt: got %0h expected 10000", bus.overrun_cnt_o); end
    checks++; if (bus.irq_o !== 1'b1) begin errors++; $display("FAIL ovr_irq: got %0b expected 1", bus.irq_o); end
    checks++; if (bus.throttle_o !== 4'h0 || bus.softrst_o !== 1'b1) begin
      errors++; $display("FAIL ovr_repl: got throttle %0h softrst %0b expected 0 1", bus.throttle_o, bus.softrst_o);
    end
    bus.intr_quota_i = '0;
    bus.irq_ack_i    = 1'b1;
    tick(1);          // t=33
    bus.irq_ack_i    = 1'b0;
    checks++; if (bus.irq_o !== 1'b0) begin errors++; $display("FAIL ovr_ack: got %0b expected 0", bus.irq_o); end
    checks++; if (bus.overrun_o !== 4'b0100) begin errors++; $display("FAIL ovr_hold: got %0h expected 4", bus.overrun_o); end
  endtask

  task automatic test_saturate();
    reset_dut();
    bus.window_len_i = 32'd1;
    bus.intr_quota_i = 4'b0001;
    bus.enable_i     = 1'b1;
    tick(1);              // t=0, period 13
    tick(13 * 254);
    checks++; if (bus.overrun_cnt_o !== 32'h0000_00FE) begin errors++; $display("FAIL sat_254: got %0h expected fe", bus.overrun_cnt_o); end
    tick(13);
    checks++; if (bus.overrun_cnt_o !== 32'h0000_00FF) begin errors++; $display("FAIL sat_255: got %0h expected ff", bus.overrun_cnt_o); end
    tick(13);
    checks++; if (bus.overrun_cnt_o !== 32'h0000_00FF) begin errors++; $display("FAIL sat_nowrap: got %0h expected ff", bus.overrun_cnt_o); end
    tick(13 * 44 + 12);   // t=13*300+12, SAMPLE
    checks++; if (bus.state_o !== 3'd4 || bus.overrun_cnt_o !== 32'h0000_00FF) begin
      errors++; $display("FAIL sat_hold: got state %0d cnt %0h expected 4 ff", bus.state_o, bus.overrun_cnt_o);
    end
    bus.clr_cnt_i = 1'b1;
    tick(1);
    bus.clr_cnt_i = 1'b0;
    checks++; if (bus.overrun_cnt_o !== 32'h0) begin errors++; $display("FAIL sat_clear: got %0h expected 0", bus.overrun_cnt_o); end
    checks++; if (bus.overrun_o !== 4'b0001 || bus.irq_o !== 1'b1) begin
      errors++; $display("FAIL sat_snapshot: got overrun %0h irq %0b expected 1 1", bus.overrun_o, bus.irq_o);
    end
  endtask

  task automatic test_disable();
    reset_dut();
    bus.window_len_i = 32'd20;
    bus.intr_quota_i = 4'b1000;
    bus.enable_i     = 1'b1;
    tick(1);          // t=0
    tick(32);         // t=32 REPL of window 2
    checks++; if (bus.overrun_o !== 4'b1000 || bus.overrun_cnt_o !== 32'h0100_0000) begin
      errors++; $display("FAIL dis_first: got overrun %0h cnt %0h expected 8 1000000", bus.overrun_o, bus.overrun_cnt_o);
    end
    bus.intr_quota_i = 4'b0010;
    tick(6);          // t=38, RUN cycle 6
    checks++; if (bus.throttle_o !== 4'b0010) begin errors++; $display("FAIL dis_throttle: got %0h expected 2", bus.throttle_o); end
    tick(1);          // t=39, RUN cycle 7
    bus.enable_i = 1'b0;
    tick(1);          // t=40
    checks++; if (bus.state_o !== 3'd1 || bus.softrst_o !== 1'b1 || bus.throttle_o !== 4'h0) begin
      errors++; $display("FAIL dis_flush: got state %0d softrst %0b throttle %0h expected 1 1 0", bus.state_o, bus.softrst_o, bus.throttle_o);
    end
    tick(1);          // t=41
    checks++; if (bus.state_o !== 3'd0 || bus.softrst_o !== 1'b0) begin
      errors++; $display("FAIL dis_idle: got state %0d softrst %0b expected 0 0", bus.state_o, bus.softrst_o);
    end
    checks++; if (bus.overrun_o !== 4'b1000 || bus.overrun_cnt_o !== 32'h0100_0000 || bus.irq_o !== 1'b1) begin
      errors++; $display("FAIL dis_unchanged: got overrun %0h cnt %0h irq %0b expected 8 1000000 1", bus.overrun_o, bus.overrun_cnt_o, bus.irq_o);
    end
    bus.intr_quota_i = '0;
    tick(1);          // t=42
    bus.enable_i = 1'b1;
    tick(1);          // t=43 REPL
    checks++; if (bus.state_o !== 3'd1 || bus.softrst_o !== 1'b1) begin
      errors++; $display("FAIL dis_reenable: got state %0d softrst %0b expected 1 1", bus.state_o, bus.softrst_o);
    end
    tick(20);         // t=63, RUN cycle 20
    checks++; if (bus.state_o !== 3'd2) begin errors++; $display("FAIL dis_run_len: got %0d expected 2", bus.state_o); end
    tick(1);          // t=64
    checks++; if (bus.state_o !== 3'd3) begin errors++; $display("FAIL dis_drain: got %0d expected 3", bus.state_o); end
  endtask

  task automatic test_len_change();
    reset_dut();
    bus.window_len_i = 32'd20;
    bus.enable_i     = 1'b1;
    tick(1);          // t=0
    tick(3);
    bus.window_len_i = 32'd5;
    tick(17);         // t=20
    checks++; if (bus.state_o !== 3'd2) begin errors++; $display("FAIL len_old_run: got %0d expected 2", bus.state_o); end
    tick(1);          // t=21
    checks++; if (bus.state_o !== 3'd3) begin errors++; $display("FAIL len_old_drain: got %0d expected 3", bus.state_o); end
    tick(11);         // t=32
    checks++; if (bus.state_o !== 3'd1 || bus.softrst_o !== 1'b1) begin
      errors++; $display("FAIL len_repl1: got state %0d softrst %0b expected 1 1", bus.state_o, bus.softrst_o);
    end
    tick(5);          // t=37
    checks++; if (bus.state_o !== 3'd2) begin errors++; $display("FAIL len_new_run: got %0d expected 2", bus.state_o); end
    tick(1);          // t=38
    checks++; if (bus.state_o !== 3'd3) begin errors++; $display("FAIL len_new_drain: got %0d expected 3", bus.state_o); end
    tick(10);         // t=48
    checks++; if (bus.state_o !== 3'd4) begin errors++; $display("FAIL len_new_sample: got %0d expected 4", bus.state_o); end
    tick(1);          // t=49, period 17
    checks++; if (bus.state_o !== 3'd1 || bus.softrst_o !== 1'b1) begin
      errors++; $display("FAIL len_repl2: got state %0d softrst %0b expected 1 1", bus.state_o, bus.softrst_o);
    end
    tick(2);          // t=51 RUN
    bus.window_len_i = '0;
    tick(1);          // t=52
    checks++; if (bus.state_o !== 3'd1 || bus.softrst_o !== 1'b1) begin
      errors++; $display("FAIL len_zero_flush: got state %0d softrst %0b expected 1 1", bus.state_o, bus.softrst_o);
    end
    tick(2);          // t=54
    checks++; if (bus.state_o !== 3'd0) begin errors++; $display("FAIL len_zero_idle: got %0d expected 0", bus.state_o); end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    bus.window_len_i = 32'd5;
    bus.intr_quota_i = 4'b0001;
    bus.enable_i     = 1'b1;
    tick(1);          // t=0
    tick(16);         // t=16 SAMPLE
    checks++; if (bus.state_o !== 3'd4 || bus.irq_o !== 1'b0) begin
      errors++; $display("FAIL ack_pre: got state %0d irq %0b expected 4 0", bus.state_o, bus.irq_o);
    end
    bus.irq_ack_i = 1'b1;
    tick(1);          // t=17
    bus.irq_ack_i = 1'b0;
    checks++; if (bus.irq_o !== 1'b1) begin errors++; $display("FAIL ack_set_wins: got %0b expected 1", bus.irq_o); end
    checks++; if (bus.overrun_o !== 4'b0001 || bus.overrun_cnt_o !== 32'h0000_0001) begin
      errors++; $display("FAIL ack_snapshot: got overrun %0h cnt %0h expected 1 1", bus.overrun_o, bus.overrun_cnt_o);
    end
    tick(8);          // t=25 DRAIN of window 2
    checks++; if (bus.state_o !== 3'd3 || bus.throttle_o !== 4'b0001) begin
      errors++; $display("FAIL rst_pre: got state %0d throttle %0h expected 3 1", bus.state_o, bus.throttle_o);
    end
    rst = 1'b1;
    tick(1);          // t=26
    checks++; if (bus.state_o !== 3'd0 || bus.softrst_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid_state: got state %0d softrst %0b expected 0 0", bus.state_o, bus.softrst_o);
    end
    checks++; if (bus.throttle_o !== 4'h0 || bus.overrun_o !== 4'h0 || bus.overrun_cnt_o !== 32'h0 || bus.irq_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid_outputs: got throttle %0h overrun %0h cnt %0h irq %0b expected 0 0 0 0",
                         bus.throttle_o, bus.overrun_o, bus.overrun_cnt_o, bus.irq_o);
    end
    rst              = 1'b0;
    bus.enable_i     = 1'b0;
    bus.intr_quota_i = '0;
    tick(1);
    checks++; if (bus.state_o !== 3'd0 || bus.softrst_o !== 1'b0) begin
      errors++; $display("FAIL rst_after: got state %0d softrst %0b expected 0 0", bus.state_o, bus.softrst_o);
    end
  endtask

  // Sequencer and final report
  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    test_reset();
    test_period();
    test_overrun();
    test_saturate();
    test_disable();
    test_len_change();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
